// File: rtl/burst_buffer_pkg.sv
// Shared constants for the burst capture buffer: FSM state encoding and
// a pointer-width helper used by the top and the storage sub-module.
package burst_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    // Index width for a DEPTH-entry array; at least one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        if (depth > 32'd1) begin
            return $clog2(depth);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/buffer_regfile.sv
// DEPTH x WIDTH storage with one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module buffer_regfile
    import burst_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PW    = ptr_width(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [PW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: one word per enabled edge.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/burst_capture_buffer.sv
// Captures a burst of DEPTH qualified words, then drains them to a
// ready/valid consumer. Control, pointers and status live here.
module burst_capture_buffer
    import burst_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       data_start,
    input  logic                       data_valid,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       abort,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_last,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] word_count,
    output logic                       start_ignored
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] word_count_q, word_count_d;
    logic          start_ignored_q, start_ignored_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q, rd_last_d;
    logic          busy_q, busy_d;
    logic          wr_en_s;

    // Next-state, pointer and status computation; abort overrides everything.
    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        word_count_d    = word_count_q;
        start_ignored_d = start_ignored_q;
        wr_en_s         = 1'b0;

        if (abort) begin
            state_d      = IDLE;
            wr_ptr_d     = {PW{1'b0}};
            rd_ptr_d     = {PW{1'b0}};
            word_count_d = {CW{1'b0}};
        end else begin
            if (data_start && (state_q != IDLE)) begin
                start_ignored_d = 1'b1;
            end else begin
                start_ignored_d = start_ignored_q;
            end

            case (state_q)
                IDLE: begin
                    if (data_start) begin
                        state_d      = CAPTURE;
                        wr_ptr_d     = {PW{1'b0}};
                        word_count_d = {CW{1'b0}};
                    end else begin
                        state_d = IDLE;
                    end
                end
                CAPTURE: begin
                    if (data_valid) begin
                        wr_en_s      = 1'b1;
                        word_count_d = word_count_q + CW'(1);
                        // Last slot: hold wr_ptr at DEPTH-1 so it never wraps.
                        if (wr_ptr_q == LAST_PTR) begin
                            state_d  = DRAIN;
                            rd_ptr_d = {PW{1'b0}};
                        end else begin
                            wr_ptr_d = wr_ptr_q + PW'(1);
                        end
                    end else begin
                        state_d = CAPTURE;
                    end
                end
                DRAIN: begin
                    if (rd_ready) begin
                        if (rd_ptr_q == LAST_PTR) begin
                            state_d      = IDLE;
                            wr_ptr_d     = {PW{1'b0}};
                            rd_ptr_d     = {PW{1'b0}};
                            word_count_d = {CW{1'b0}};
                        end else begin
                            rd_ptr_d = rd_ptr_q + PW'(1);
                        end
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: begin
                    state_d      = IDLE;
                    wr_ptr_d     = {PW{1'b0}};
                    rd_ptr_d     = {PW{1'b0}};
                    word_count_d = {CW{1'b0}};
                end
            endcase
        end

        rd_valid_d = (state_d == DRAIN);
        busy_d     = (state_d != IDLE);
        if ((state_d == DRAIN) && (rd_ptr_d == LAST_PTR)) begin
            rd_last_d = 1'b1;
        end else begin
            rd_last_d = 1'b0;
        end
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            wr_ptr_q        <= {PW{1'b0}};
            rd_ptr_q        <= {PW{1'b0}};
            word_count_q    <= {CW{1'b0}};
            start_ignored_q <= 1'b0;
            rd_valid_q      <= 1'b0;
            rd_last_q       <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            word_count_q    <= word_count_d;
            start_ignored_q <= start_ignored_d;
            rd_valid_q      <= rd_valid_d;
            rd_last_q       <= rd_last_d;
            busy_q          <= busy_d;
        end
    end

    buffer_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_regfile (
        .clock   (clock),
        .wr_en   (wr_en_s && !reset),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    assign rd_valid      = rd_valid_q;
    assign rd_last       = rd_last_q;
    assign busy          = busy_q;
    assign word_count    = word_count_q;
    assign start_ignored = start_ignored_q;

endmodule

// File: tb/tb_burst_capture_buffer.sv
// Bench for burst_capture_buffer: a fixed vector table for the basic burst,
// directed corner-case sequences, and randomized traffic against a queue model.
module tb_burst_capture_buffer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic              clock = 1'b0;
    logic              reset, data_start, data_valid, abort, rd_ready;
    logic [WIDTH-1:0]  data_in;
    logic              rd_valid, rd_last, busy, start_ignored;
    logic [WIDTH-1:0]  rd_data;
    logic [3:0]        word_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: burst contents as a queue, plus phase and read index.
    int               m_mode;   // 0 idle, 1 capture, 2 drain
    logic [WIDTH-1:0] m_q[$];
    int               m_rd;
    bit               m_sticky;

    typedef struct {
        logic             rst, start, valid, abrt, ready;
        logic [WIDTH-1:0] din;
        logic             e_valid, e_last, e_busy;
        logic [3:0]       e_wc;
        logic [WIDTH-1:0] e_data;
    } vec_t;

    vec_t tbl[18];

    burst_capture_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .data_start    (data_start),
        .data_valid    (data_valid),
        .data_in       (data_in),
        .abort         (abort),
        .rd_ready      (rd_ready),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_last       (rd_last),
        .busy          (busy),
        .word_count    (word_count),
        .start_ignored (start_ignored)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, s, v, a, rd, input logic [WIDTH-1:0] d);
        if (r) begin
            m_mode = 0; m_q.delete(); m_rd = 0; m_sticky = 0;
        end else if (a) begin
            m_mode = 0; m_q.delete(); m_rd = 0;
        end else if (m_mode == 0) begin
            if (s) begin
                m_mode = 1; m_q.delete();
            end
        end else if (m_mode == 1) begin
            if (s) m_sticky = 1;
            if (v) begin
                m_q.push_back(d);
                if (m_q.size() == DEPTH) begin
                    m_mode = 2; m_rd = 0;
                end
            end
        end else begin
            if (s) m_sticky = 1;
            if (rd) begin
                if (m_rd == DEPTH - 1) begin
                    m_mode = 0; m_q.delete(); m_rd = 0;
                end else begin
                    m_rd++;
                end
            end
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_mode == 2));
        chk({tag, ".busy"}, 32'(busy), 32'(m_mode != 0));
        chk({tag, ".rd_last"}, 32'(rd_last), 32'((m_mode == 2) && (m_rd == DEPTH - 1)));
        chk({tag, ".word_count"}, 32'(word_count), 32'(m_q.size()));
        chk({tag, ".start_ignored"}, 32'(start_ignored), 32'(m_sticky));
        if (m_mode == 2) chk({tag, ".rd_data"}, 32'(rd_data), 32'(m_q[m_rd]));
    endtask

    // Apply one cycle of inputs, advance the model on the edge, check after it.
    task automatic step(input string tag, input logic r, s, v, a, rd, input logic [WIDTH-1:0] d);
        reset = r; data_start = s; data_valid = v; abort = a; rd_ready = rd; data_in = d;
        @(posedge clock);
        model_edge(r, s, v, a, rd, d);
        #1;
        compare_model(tag);
    endtask

    task automatic fill(input string tag, input logic [WIDTH-1:0] base);
        step(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < DEPTH; i++) step(tag, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, base + 16'(i));
    endtask

    initial begin
        reset = 1'b1; data_start = 1'b0; data_valid = 1'b0; abort = 1'b0;
        rd_ready = 1'b0; data_in = 16'h0000;
        m_mode = 0; m_rd = 0; m_sticky = 0;

        // Basic burst vectors: reset, start, 8 captures, 8 reads.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0000};
        for (int i = 0; i < 8; i++)
            tbl[2 + i] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'(i + 1),
                           (i == 7), 1'b0, 1'b1, 4'(i + 1), 16'h0001};
        for (int k = 0; k < 8; k++)
            tbl[10 + k] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000,
                            (k < 7), (k == 6), (k < 7), (k < 7) ? 4'd8 : 4'd0, 16'(k + 2)};

        for (int i = 0; i < 18; i++) begin
            step("tbl", tbl[i].rst, tbl[i].start, tbl[i].valid, tbl[i].abrt, tbl[i].ready, tbl[i].din);
            chk($sformatf("tbl%0d.rd_valid", i), 32'(rd_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d.rd_last", i), 32'(rd_last), 32'(tbl[i].e_last));
            chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d.word_count", i), 32'(word_count), 32'(tbl[i].e_wc));
            if (tbl[i].e_valid) chk($sformatf("tbl%0d.rd_data", i), 32'(rd_data), 32'(tbl[i].e_data));
        end

        // data_valid gaps: only valid cycles store and count.
        step("gap", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            step("gap", 1'b0, 1'b0, (i % 2 == 0), 1'b0, 1'b0, 16'h0100 + 16'(i));
            chk("gap.count", 32'(word_count), 32'((i / 2) + 1));
        end
        for (int i = 0; i < DEPTH; i++) begin
            chk("gap.order", 32'(rd_data), 32'(16'h0100 + 16'(2 * i)));
            step("gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        end

        // Consumer stall on word 0x0004.
        fill("stall", 16'h0001);
        for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hDEAD);
            chk("stall.data", 32'(rd_data), 32'h0004);
            chk("stall.valid", 32'(rd_valid), 32'h1);
        end
        for (int i = 0; i < DEPTH - 3; i++) step("stall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        chk("stall.done", 32'(busy), 32'h0);

        // Restart attempts during capture and drain are ignored but flagged.
        step("ign", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < DEPTH; i++) step("ign", 1'b0, (i == 3), 1'b1, 1'b0, 1'b0, 16'h0200 + 16'(i));
        for (int i = 0; i < DEPTH; i++) step("ign", 1'b0, (i == 2), 1'b0, 1'b0, 1'b1, 16'h0000);
        chk("ign.sticky", 32'(start_ignored), 32'h1);
        chk("ign.idle", 32'(busy), 32'h0);

        // Abort together with a valid word after 3 captures, then a fresh burst.
        step("abort", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) step("abort", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0300 + 16'(i));
        step("abort", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h03FF);
        chk("abort.busy", 32'(busy), 32'h0);
        chk("abort.count", 32'(word_count), 32'h0);
        fill("abort", 16'h0A00);
        for (int i = 0; i < DEPTH; i++) begin
            chk("abort.fresh", 32'(rd_data), 32'(16'h0A00 + 16'(i)));
            step("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        end

        // Reset in the middle of a drain.
        fill("rst", 16'h0B00);
        step("rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        step("rst", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        chk("rst.valid", 32'(rd_valid), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.count", 32'(word_count), 32'h0);
        chk("rst.sticky", 32'(start_ignored), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step("rand", ($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 2),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 9) < 6), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_capture_buffer.md
BURST_CAPTURE_BUFFER -- requirements
Module: burst_capture_buffer

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, words per burst (>=2).
REQ-003 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  reset, synchronous and active-high.
REQ-005 Port data_start  input  1  burst request; sampled only in IDLE.
REQ-006 Port data_valid  input  1  qualifies data_in during capture.
REQ-007 Port data_in  input  WIDTH  incoming word.
REQ-008 Port abort  input  1  cancels the current burst and returns to IDLE.
REQ-009 Port rd_ready  input  1  consumer accepts rd_data this cycle.
REQ-010 Port rd_valid  output  1  rd_data holds a buffered word.
REQ-011 Port rd_data  output  WIDTH  buffered word at the read pointer.
REQ-012 Port rd_last  output  1  rd_data is word DEPTH-1 of the burst.
REQ-013 Port busy  output  1  state is not IDLE.
REQ-014 Port word_count  output  $clog2(DEPTH+1)  words captured in the current burst.
REQ-015 Port start_ignored  output  1  sticky flag: data_start was seen while not in IDLE.

Function
REQ-016 FSM states SHALL be IDLE, CAPTURE and DRAIN.
REQ-017 IDLE with data_start=1 SHALL go to CAPTURE next edge with wr_ptr=0 and word_count=0; the data_in of the start cycle is not captured.
REQ-018 In CAPTURE, each edge with data_valid=1 SHALL write data_in to buffer[wr_ptr], then increment wr_ptr and word_count; data_valid=0 SHALL stall without writing.
REQ-019 The write of word DEPTH-1 SHALL move the FSM to DRAIN on the same edge, with rd_ptr=0.
REQ-020 rd_valid SHALL be 1 exactly when the state is DRAIN; rd_data SHALL be buffer[rd_ptr] with no added register stage, so word 0 appears the cycle after the last capture.
REQ-021 A DRAIN edge with rd_ready=1 SHALL advance rd_ptr; rd_ready=0 SHALL hold rd_data and rd_valid stable.
REQ-022 rd_last SHALL be 1 only when in DRAIN and rd_ptr=DEPTH-1.
REQ-023 Acceptance of the rd_last word SHALL return the FSM to IDLE and clear word_count.
REQ-024 data_start in CAPTURE or DRAIN SHALL NOT restart the burst; it SHALL set start_ignored, which stays set until reset.
REQ-025 abort=1 in any state SHALL force IDLE next edge and clear the pointers and word_count; buffer contents need not be cleared.
REQ-026 abort has priority over data_start, data_valid and rd_ready in the same cycle.
REQ-027 Pointers SHALL never exceed DEPTH-1; no wrap-around occurs within a burst.
REQ-028 data_valid outside CAPTURE and rd_ready outside DRAIN SHALL have no effect.

Reset
REQ-029 Reset SHALL force IDLE; wr_ptr, rd_ptr, word_count, start_ignored, rd_valid and rd_last SHALL be 0.
REQ-030 Reset SHALL take priority over abort and all other inputs; buffer storage is not reset.
REQ-031 rd_data after reset SHALL be treated as don't-care while rd_valid=0.

Structure
REQ-032 The state encoding (IDLE, CAPTURE, DRAIN) SHALL be defined as constants in the shared package burst_buffer_pkg.
REQ-033 Storage SHALL be one sub-module, buffer_regfile (DEPTH x WIDTH, one write port, one asynchronous read port); control and pointers stay in the top module.

Verification
REQ-034 Scenario: reset, pulse data_start, drive data_valid=1 with 0x0001..0x0008 -> rd_valid rises the next cycle; with rd_ready=1, rd_data reads 0x0001..0x0008; rd_last is high only on 0x0008; busy then falls.
REQ-035 Scenario: data_valid gaps (1,0,1,0,...) during capture -> only the valid words are stored, in order, and word_count steps only on valid cycles.
REQ-036 Scenario: rd_ready low for 3 cycles mid-drain on word 0x0004 -> rd_data holds 0x0004 and rd_valid stays 1 throughout the stall.
REQ-037 Scenario: data_start pulsed during CAPTURE and again during DRAIN -> burst proceeds unchanged and start_ignored=1 until reset.
REQ-038 Scenario: abort after 3 captured words, same cycle as data_valid -> next cycle is IDLE with word_count=0; a new burst then captures 8 fresh words correctly.
REQ-039 Scenario: reset asserted mid-DRAIN with rd_ready=1 -> next cycle rd_valid=0, busy=0, word_count=0, start_ignored=0.
